snow3g_ks_ctrl: RTL and testbench

- Sequencing controller for the SNOW 3G keystream core. It drives the LFSR and FSM datapath, including the MULalpha/DIValpha feedback logic.
- Sequence per run: key/IV load, 32 initialisation clocks, one discarded keystream-mode clock, then N keystream words under a valid/ready handshake.
- Sits beside the datapath at the cipher top level. It owns no key or state data, only control strobes and counters.

---
 rtl/snow3g_pkg.sv | 16 +
 rtl/snow3g_ks_ctrl.sv | 114 +++++++++++
 tb/tb_snow3g_ks_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/snow3g_pkg.sv
// Shared definitions for the SNOW 3G keystream control path.
package snow3g_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        INIT,
        DISCARD,
        KS,
        DONE
    } state_e;

    localparam int INIT_ROUNDS_DEF = 32;
    localparam int CNT_W_DEF       = 16;

endpackage

// File: rtl/snow3g_ks_ctrl.sv
// Sequencing controller for the SNOW 3G LFSR/FSM datapath: load, init rounds,
// one discarded step, then a valid/ready stream of keystream words.
module snow3g_ks_ctrl
    import snow3g_pkg::*;
#(
    parameter int INIT_ROUNDS = INIT_ROUNDS_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_words,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             dp_load,
    output logic             dp_clock,
    output logic             dp_init_mode,
    output logic             ks_valid,
    input  logic             ks_ready,
    output logic             ks_last
);

    localparam int RND_W = $clog2(INIT_ROUNDS + 1);

    state_e           state_q, state_d;
    logic [RND_W-1:0] rnd_q, rnd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rnd_d        = rnd_q;
        cnt_d        = cnt_q;
        busy         = (state_q != IDLE);
        done         = 1'b0;
        aborted      = 1'b0;
        dp_load      = 1'b0;
        dp_clock     = 1'b0;
        dp_init_mode = 1'b0;
        ks_valid     = 1'b0;
        ks_last      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = num_words;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                dp_load = 1'b1;
                rnd_d   = '0;
                state_d = INIT;
            end
            INIT: begin
                dp_clock     = 1'b1;
                dp_init_mode = 1'b1;
                rnd_d        = rnd_q + RND_W'(1);
                if (rnd_q == RND_W'(INIT_ROUNDS - 1)) begin
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                dp_clock = 1'b1;
                state_d  = (cnt_q == '0) ? DONE : KS;
            end
            KS: begin
                ks_valid = 1'b1;
                ks_last  = (cnt_q == CNT_W'(1));
                // Stepping the datapath only on handshake keeps z stable under backpressure.
                dp_clock = ks_ready;
                if (ks_ready) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Cancel overrides everything: no datapath step, no word consumed, no done.
        if (abort && (state_q != IDLE)) begin
            state_d      = IDLE;
            rnd_d        = rnd_q;
            cnt_d        = cnt_q;
            aborted      = 1'b1;
            done         = 1'b0;
            dp_load      = 1'b0;
            dp_clock     = 1'b0;
            dp_init_mode = 1'b0;
        end
    end

endmodule

// File: tb/tb_snow3g_ks_ctrl.sv
// Randomised and directed bench for snow3g_ks_ctrl against a cycle-count model.
module tb_snow3g_ks_ctrl;

    localparam int CNT_W = 10;
    localparam int IR    = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] num_words;
    logic             abort;
    logic             busy, done, aborted, dp_load, dp_clock, dp_init_mode;
    logic             ks_valid, ks_ready, ks_last;

    snow3g_ks_ctrl #(.INIT_ROUNDS(IR), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .num_words    (num_words),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .dp_load      (dp_load),
        .dp_clock     (dp_clock),
        .dp_init_mode (dp_init_mode),
        .ks_valid     (ks_valid),
        .ks_ready     (ks_ready),
        .ks_last      (ks_last)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", nm, act, act, exp, exp, $time);
        end
    endtask

    function automatic int outs();
        return int'({busy, done, aborted, dp_load, dp_clock, dp_init_mode, ks_valid, ks_last});
    endfunction

    // Model: a run is described by cycles elapsed since start was sampled.
    bit m_act = 0;
    bit m_fin = 0;
    int m_k   = 0;
    int m_rem = 0;
    int s_edge = 0;

    int st_clk, st_hs, st_valid1, st_done, st_abort, st_last, st_load;
    int done_total = 0;

    always @(negedge clk) begin
        logic [7:0] e;
        int ph;
        int rel;
        e = 8'h00;
        if (!rst_n) begin
            m_act = 0;
        end else if (!m_act) begin
            if (start) begin
                m_act = 1; m_k = 1; m_rem = int'(num_words); m_fin = 0; s_edge = cyc;
                st_clk = 0; st_hs = 0; st_valid1 = -1; st_done = -1;
                st_abort = -1; st_last = -1; st_load = -1;
            end
        end else begin
            if (m_k == 1)            ph = 1;
            else if (m_k <= IR + 1)  ph = 2;
            else if (m_k == IR + 2)  ph = 3;
            else if (m_fin)          ph = 5;
            else                     ph = 4;
            e[7] = 1'b1;
            if (ph == 4) begin
                e[1] = 1'b1;
                e[0] = (m_rem == 1);
            end
            if (abort) begin
                e[5]  = 1'b1;
                m_act = 0;
            end else begin
                case (ph)
                    1: e[4] = 1'b1;
                    2: e[3:2] = 2'b11;
                    3: e[3] = 1'b1;
                    4: e[3] = ks_ready;
                    default: e[6] = 1'b1;
                endcase
                m_k++;
                if (ph == 3 && m_rem == 0) m_fin = 1;
                if (ph == 4 && ks_ready) begin
                    m_rem--;
                    if (m_rem == 0) m_fin = 1;
                end
                if (ph == 5) m_act = 0;
            end
        end
        chk("outs", outs(), int'(e));

        rel = cyc - s_edge;
        if (dp_clock) st_clk++;
        if (dp_load) st_load = rel;
        if (ks_valid && st_valid1 < 0) st_valid1 = rel;
        if (ks_valid && ks_ready && !abort) begin
            st_hs++;
            if (ks_last) st_last = rel;
        end
        if (done) begin st_done = rel; done_total++; end
        if (aborted) st_abort = rel;
    end

    task automatic start_run(input int nw);
        start = 1'b1;
        num_words = CNT_W'(nw);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit && busy; i++) begin
            @(posedge clk); #1;
        end
        chk("idle_timeout", int'(busy), 0);
    endtask

    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        rst_n = 1'b0; start = 1'b0; num_words = '0; abort = 1'b0; ks_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", outs(), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset mid-INIT
        start_run(6);
        repeat (9) @(posedge clk);
        #1;
        chk("pre_rst_init", int'(dp_init_mode), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", outs(), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_idle_busy", int'(busy), 0);
        chk("rst_no_done", done_total, 0);

        // Nominal, 4 words
        ks_ready = 1'b1;
        start_run(4);
        wait_idle(100);
        chk("nom_load", st_load, 1);
        chk("nom_first_valid", st_valid1, 35);
        chk("nom_last", st_last, 38);
        chk("nom_done", st_done, 39);
        chk("nom_clocks", st_clk, 37);
        chk("nom_hs", st_hs, 4);

        // Backpressure
        ks_ready = 1'b0;
        start_run(3);
        repeat (34) @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            ks_ready = pat[i];
            @(posedge clk); #1;
        end
        wait_idle(50);
        chk("bp_hs", st_hs, 3);
        chk("bp_first_valid", st_valid1, 35);
        chk("bp_done", st_done, 41);
        chk("bp_clocks", st_clk, 36);

        // Zero length
        ks_ready = 1'b1;
        start_run(0);
        wait_idle(100);
        chk("zero_done", st_done, 35);
        chk("zero_clocks", st_clk, 33);
        chk("zero_valid", st_valid1, -1);

        // Abort in INIT at cycle 20
        start_run(8);
        repeat (19) @(posedge clk);
        #1;
        abort = 1'b1;
        #1;
        chk("abort_clk_gated", int'(dp_clock), 0);
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_idle", int'(busy), 0);
        chk("abort_rel", st_abort, 20);
        chk("abort_no_done", st_done, -1);
        chk("abort_clocks", st_clk, 18);
        abort = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_idle_nopulse", st_abort, 20);

        // Abort in KS with ks_ready high
        ks_ready = 1'b1;
        start_run(5);
        repeat (35) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_ks_idle", int'(busy), 0);
        chk("abort_ks_hs", st_hs, 1);
        chk("abort_ks_no_done", st_done, -1);

        // Start while busy, then restart right after done
        start_run(2);
        repeat (14) @(posedge clk);
        #1;
        start = 1'b1; num_words = CNT_W'(9);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk); #1;
        end
        chk("busy_start_done_seen", int'(done), 1);
        chk("busy_start_hs", st_hs, 2);
        start = 1'b1; num_words = CNT_W'(7);
        @(posedge clk); #1;
        num_words = CNT_W'(3);
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(100);
        chk("restart_load", st_load, 1);
        chk("restart_hs", st_hs, 3);
        chk("restart_done", st_done, 38);

        // All-ones word count
        start_run((1 << CNT_W) - 1);
        wait_idle(1200);
        chk("max_hs", st_hs, (1 << CNT_W) - 1);
        chk("max_last", st_last, 34 + (1 << CNT_W) - 1);
        chk("max_done", st_done, 35 + (1 << CNT_W) - 1);

        // Random traffic
        for (int r = 0; r < 40; r++) begin
            start_run($urandom_range(0, 12));
            for (int c = 0; c < 400 && busy; c++) begin
                ks_ready  = 1'($urandom_range(0, 1));
                abort     = ($urandom_range(0, 199) == 0);
                start     = 1'($urandom_range(0, 1));
                num_words = CNT_W'($urandom_range(0, 20));
                @(posedge clk); #1;
            end
            start = 1'b0; abort = 1'b0;
            chk("rand_idle", int'(busy), 0);
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
